// File: rtl/transmit_arbiter_if.sv
// Request/transmit bundle shared by the word sources, transmit_arbiter and data_transmitter.
// master = requesters plus transmitter side, slave = the arbiter.
interface transmit_arbiter_if;
  logic [2:0]  req;
  logic [63:0] data0;
  logic [63:0] data1;
  logic [63:0] data2;
  logic [2:0]  ack;
  logic        tx_send;
  logic [63:0] tx_data;
  logic        tx_busy;
  logic [1:0]  grant;
  logic        active;
  logic        timeout;

  modport master (
    output req, data0, data1, data2, tx_busy,
    input  ack, tx_send, tx_data, grant, active, timeout
  );

  modport slave (
    input  req, data0, data1, data2, tx_busy,
    output ack, tx_send, tx_data, grant, active, timeout
  );
endinterface

// File: rtl/transmit_arbiter.sv
// Round-robin sharing of one serial transmitter among three 64-bit word sources; grant to tx_send 1 cycle.
// Holds off while tx_busy is high in IDLE; optional WAIT_START abort via TRANSMIT_ARBITER_TIMEOUT_EN.
module transmit_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst,
  transmit_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_START, WAIT_END, ACK} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] winner;

  // First set request at or after p, scanning modulo 3; lowest offset wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    int c;
    rr_pick = 2'd3;
    for (int i = 2; i >= 0; i--) begin
      c = (int'(p) + i) % 3;
      if (r[c]) rr_pick = 2'(c);
    end
  endfunction

  assign winner = rr_pick(bus.req, ptr);

`ifdef TRANSMIT_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = 1'(TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      bus.ack     <= 3'b000;
      bus.tx_send <= 1'b0;
      bus.tx_data <= '0;
      bus.grant   <= 2'd3;
      bus.active  <= 1'b0;
      bus.timeout <= 1'b0;
`ifdef TRANSMIT_ARBITER_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      bus.tx_send <= 1'b0;
      bus.ack     <= 3'b000;
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req != 3'b000 && !bus.tx_busy) begin
            state       <= SEND;
            bus.grant   <= winner;
            bus.tx_send <= 1'b1;
            bus.active  <= 1'b1;
            case (winner)
              2'd0:    bus.tx_data <= bus.data0;
              2'd1:    bus.tx_data <= bus.data1;
              default: bus.tx_data <= bus.data2;
            endcase
          end
        end
        SEND: begin
          state <= WAIT_START;
`ifdef TRANSMIT_ARBITER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT_START: begin
          if (bus.tx_busy) begin
            state <= WAIT_END;
`ifdef TRANSMIT_ARBITER_TIMEOUT_EN
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // Transmitter never started: release the requester anyway.
            state       <= ACK;
            bus.ack     <= 3'b001 << bus.grant;
            bus.timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        WAIT_END: begin
          if (!bus.tx_busy) begin
            state   <= ACK;
            bus.ack <= 3'b001 << bus.grant;
          end
        end
        ACK: begin
          state      <= IDLE;
          ptr        <= (bus.grant == 2'd2) ? 2'd0 : bus.grant + 2'd1;
          bus.grant  <= 2'd3;
          bus.active <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
